// File: rtl/approx_error_monitor.sv
// Error-metric checker for exhaustive approximate-circuit evaluation: scores 2^PI_W vectors
// in ascending input order. Define APPROX_ERR_LOG_EN to capture the first mismatching vector.
module approx_error_monitor #(
  parameter int PI_W  = 7,
  parameter int PO_W  = 4,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PI_W-1:0]  in_pi,
  input  logic [PO_W-1:0]  in_apx,
  input  logic [PO_W-1:0]  in_ref,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_count,
  output logic [ACC_W-1:0] hd_sum,
  output logic [ACC_W-1:0] ae_sum,
  output logic [PO_W-1:0]  max_ae,
  output logic             seq_err,
  output logic [PI_W-1:0]  first_pi,
  output logic [PO_W-1:0]  first_apx,
  output logic [PO_W-1:0]  first_ref
);

  localparam int POP_W = $clog2(PO_W + 1);
  // One extra index bit keeps the last-vector compare distinct from the wrapped value.
  localparam logic [PI_W:0] LAST_IDX = {1'b0, {PI_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              hs;
  logic              start_run;
  logic              vec_mis;
  logic              pi_mis;
  logic [PI_W:0]     exp_idx;
  logic [PO_W-1:0]   diff_bits;
  logic [POP_W-1:0]  pop_cnt;
  logic [PO_W-1:0]   abs_diff;
  logic              s1_valid;
  logic              s1_mis;
  logic [POP_W-1:0]  s1_pop;
  logic [PO_W-1:0]   s1_abs;

  assign hs        = in_valid & in_ready;
  assign start_run = start & ((state == IDLE) | (state == DONE));
  assign vec_mis   = (in_apx != in_ref);
  assign pi_mis    = ({1'b0, in_pi} != exp_idx);

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  always_comb begin
    diff_bits = in_apx ^ in_ref;
    pop_cnt   = '0;
    for (int i = 0; i < PO_W; i++) begin
      pop_cnt = pop_cnt + POP_W'(diff_bits[i]);
    end
    abs_diff = (in_apx >= in_ref) ? (in_apx - in_ref) : (in_ref - in_apx);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (hs && (exp_idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered straight from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == RUN);
      busy     <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done     <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx   <= '0;
      seq_err   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_mis    <= 1'b0;
      s1_pop    <= '0;
      s1_abs    <= '0;
      err_count <= '0;
      hd_sum    <= '0;
      ae_sum    <= '0;
      max_ae    <= '0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_mis  <= vec_mis;
        s1_pop  <= pop_cnt;
        s1_abs  <= abs_diff;
        exp_idx <= exp_idx + 1'b1;
        if (pi_mis) seq_err <= 1'b1;
      end
      if (start_run) begin
        exp_idx   <= '0;
        seq_err   <= 1'b0;
        err_count <= '0;
        hd_sum    <= '0;
        ae_sum    <= '0;
        max_ae    <= '0;
      end else if (s1_valid) begin
        err_count <= sat_add(err_count, ACC_W'(s1_mis));
        hd_sum    <= sat_add(hd_sum, ACC_W'(s1_pop));
        ae_sum    <= sat_add(ae_sum, ACC_W'(s1_abs));
        if (s1_abs > max_ae) max_ae <= s1_abs;
      end
    end
  end

`ifdef APPROX_ERR_LOG_EN
  logic logged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logged    <= 1'b0;
      first_pi  <= '0;
      first_apx <= '0;
      first_ref <= '0;
    end else if (start_run) begin
      logged    <= 1'b0;
      first_pi  <= '0;
      first_apx <= '0;
      first_ref <= '0;
    end else if (hs && vec_mis && !logged) begin
      logged    <= 1'b1;
      first_pi  <= in_pi;
      first_apx <= in_apx;
      first_ref <= in_ref;
    end
  end
`else
  assign first_pi  = '0;
  assign first_apx = '0;
  assign first_ref = '0;
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomised/directed bench for approx_error_monitor; a wide (ACC_W=32) and a narrow
// (ACC_W=8) instance share stimulus and are scored against a per-run arithmetic model.
module tb_approx_error_monitor;

  localparam int PI_W = 7;
  localparam int PO_W = 4;
  localparam int N    = 1 << PI_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [PI_W-1:0] in_pi = '0;
  logic [PO_W-1:0] in_apx = '0;
  logic [PO_W-1:0] in_ref = '0;

  logic            in_ready, busy, done, seq_err;
  logic [31:0]     err_count, hd_sum, ae_sum;
  logic [PO_W-1:0] max_ae, first_apx, first_ref;
  logic [PI_W-1:0] first_pi;

  logic            in_ready8, busy8, done8, seq_err8;
  logic [7:0]      err_count8, hd_sum8, ae_sum8;
  logic [PO_W-1:0] max_ae8, first_apx8, first_ref8;
  logic [PI_W-1:0] first_pi8;

  int checks = 0;
  int errors = 0;

  logic [PI_W-1:0] v_pi  [N];
  logic [PO_W-1:0] v_apx [N];
  logic [PO_W-1:0] v_ref [N];

  approx_error_monitor #(.PI_W(PI_W), .PO_W(PO_W), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pi(in_pi), .in_apx(in_apx), .in_ref(in_ref), .busy(busy), .done(done),
    .err_count(err_count), .hd_sum(hd_sum), .ae_sum(ae_sum), .max_ae(max_ae),
    .seq_err(seq_err), .first_pi(first_pi), .first_apx(first_apx), .first_ref(first_ref)
  );

  approx_error_monitor #(.PI_W(PI_W), .PO_W(PO_W), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .in_pi(in_pi), .in_apx(in_apx), .in_ref(in_ref), .busy(busy8), .done(done8),
    .err_count(err_count8), .hd_sum(hd_sum8), .ae_sum(ae_sum8), .max_ae(max_ae8),
    .seq_err(seq_err8), .first_pi(first_pi8), .first_apx(first_apx8), .first_ref(first_ref8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic rdy, input logic bsy, input logic dn);
    check_output({tag, " in_ready"}, in_ready, rdy);
    check_output({tag, " busy"}, busy, bsy);
    check_output({tag, " done"}, done, dn);
    check_output({tag, " in_ready8"}, in_ready8, rdy);
    check_output({tag, " busy8"}, busy8, bsy);
    check_output({tag, " done8"}, done8, dn);
  endtask

  task automatic check_idle_zero(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b0);
    check_output({tag, " err_count"}, err_count, 0);
    check_output({tag, " hd_sum"}, hd_sum, 0);
    check_output({tag, " ae_sum"}, ae_sum, 0);
    check_output({tag, " max_ae"}, max_ae, 0);
    check_output({tag, " seq_err"}, seq_err, 0);
    check_output({tag, " first_pi"}, first_pi, 0);
    check_output({tag, " first_apx"}, first_apx, 0);
    check_output({tag, " first_ref"}, first_ref, 0);
    check_output({tag, " err_count8"}, err_count8, 0);
    check_output({tag, " ae_sum8"}, ae_sum8, 0);
  endtask

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  // Reference metrics derived directly from the scored vector list.
  task automatic check_metrics(input string tag);
    int e = 0, h = 0, a = 0, m = 0, d;
    int fi = -1;
    logic s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v_apx[i] != v_ref[i]) begin
        e++;
        if (fi < 0) fi = i;
      end
      h += $countones(v_apx[i] ^ v_ref[i]);
      d = int'(v_apx[i]) - int'(v_ref[i]);
      if (d < 0) d = -d;
      a += d;
      if (d > m) m = d;
      if (v_pi[i] != PI_W'(i)) s = 1'b1;
    end
    check_output({tag, " err_count"}, err_count, e);
    check_output({tag, " hd_sum"}, hd_sum, h);
    check_output({tag, " ae_sum"}, ae_sum, a);
    check_output({tag, " max_ae"}, max_ae, m);
    check_output({tag, " seq_err"}, seq_err, s);
    check_output({tag, " err_count8"}, err_count8, sat(e, 255));
    check_output({tag, " hd_sum8"}, hd_sum8, sat(h, 255));
    check_output({tag, " ae_sum8"}, ae_sum8, sat(a, 255));
    check_output({tag, " max_ae8"}, max_ae8, m);
    check_output({tag, " seq_err8"}, seq_err8, s);
`ifdef APPROX_ERR_LOG_EN
    check_output({tag, " first_pi"}, first_pi, (fi < 0) ? 0 : v_pi[fi]);
    check_output({tag, " first_apx"}, first_apx, (fi < 0) ? 0 : v_apx[fi]);
    check_output({tag, " first_ref"}, first_ref, (fi < 0) ? 0 : v_ref[fi]);
    check_output({tag, " first_pi8"}, first_pi8, (fi < 0) ? 0 : v_pi[fi]);
`else
    check_output({tag, " first_pi"}, first_pi, 0);
    check_output({tag, " first_apx"}, first_apx, 0);
    check_output({tag, " first_ref"}, first_ref, 0);
`endif
  endtask

  task automatic fill_vectors(input int mode);
    for (int i = 0; i < N; i++) begin
      v_pi[i]  = PI_W'(i);
      v_ref[i] = PO_W'(i);
      v_apx[i] = PO_W'(i);
      case (mode)
        1: if (i == 5) begin v_apx[i] = 4'b1010; v_ref[i] = 4'b0101; end
        2: v_pi[i] = (i < 3) ? PI_W'(i) : PI_W'(i + 1);
        3: begin v_ref[i] = PO_W'($urandom); v_apx[i] = v_ref[i] ^ 4'b0001; end
        4: begin v_apx[i] = 4'd15; v_ref[i] = 4'd0; end
        5: begin v_apx[i] = PO_W'($urandom); v_ref[i] = PO_W'($urandom); end
        6: begin
          v_apx[i] = PO_W'($urandom);
          v_ref[i] = ($urandom_range(0, 1) == 0) ? v_apx[i] : PO_W'($urandom);
          if ($urandom_range(0, 15) == 0) v_pi[i] = PI_W'($urandom);
        end
        default: ;
      endcase
    end
  endtask

  // gap_mode: 0 valid held high, 1 toggling, 2 random gaps plus a stray start mid-run.
  task automatic apply_stimulus(input string tag, input int gap_mode, input bit start_valid,
                                input int stop_after);
    int k = 0;
    int cyc = 0;
    bit v;
    @(negedge clk);
    start    = 1'b1;
    in_valid = start_valid;
    in_pi    = v_pi[0];
    in_apx   = v_apx[0];
    in_ref   = v_ref[0];
    check_output({tag, " ready_before_start"}, in_ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_flags({tag, " after_start"}, 1'b1, 1'b1, 1'b0);
    check_output({tag, " cleared err_count"}, err_count, 0);
    check_output({tag, " cleared seq_err"}, seq_err, 0);
    while (k < stop_after && cyc < 4000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      start    = (gap_mode == 2) && (cyc == 10);
      in_valid = v;
      in_pi    = v ? v_pi[k]  : PI_W'($urandom);
      in_apx   = v ? v_apx[k] : PO_W'($urandom);
      in_ref   = v ? v_ref[k] : PO_W'($urandom);
      @(negedge clk);
      check_output({tag, " in_ready_run"}, in_ready, 1);
      @(posedge clk);
      if (v) k++;
      cyc++;
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check_output({tag, " handshakes"}, k, stop_after);
    if (stop_after == N) begin
      check_flags({tag, " drain"}, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_flags({tag, " done"}, 1'b0, 1'b0, 1'b1);
      check_metrics(tag);
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_pi    = PI_W'($urandom);
        in_apx   = PO_W'($urandom);
        in_ref   = PO_W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check_flags({tag, " hold"}, 1'b0, 1'b0, 1'b1);
      check_metrics({tag, " hold"});
    end
  endtask

  initial begin
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    $display("[TB] run: clean, start with in_valid");
    fill_vectors(0);
    apply_stimulus("clean", 0, 1'b1, N);

    $display("[TB] run: single mismatch at 5");
    fill_vectors(1);
    apply_stimulus("single", 0, 1'b0, N);

    $display("[TB] run: skipped index 3");
    fill_vectors(2);
    apply_stimulus("skip", 0, 1'b0, N);

    $display("[TB] run: toggling valid, lsb errors");
    fill_vectors(3);
    apply_stimulus("toggle", 1, 1'b0, N);

    $display("[TB] run: saturation");
    fill_vectors(4);
    apply_stimulus("saturate", 0, 1'b0, N);

    $display("[TB] run: reset after 40 handshakes");
    fill_vectors(5);
    apply_stimulus("partial", 2, 1'b0, 40);
    rst = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_zero("after_mid_reset");
    fill_vectors(0);
    apply_stimulus("clean2", 0, 1'b0, N);

    $display("[TB] run: random vectors with gaps");
    fill_vectors(5);
    apply_stimulus("random", 2, 1'b0, N);
    fill_vectors(6);
    apply_stimulus("random_seq", 2, 1'b0, N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
